// File: rtl/video_pixel_feed_if.sv
// Timing, FIFO-head and video-output signals between the sync generator,
// the frame FIFO, video_pixel_feed and the output encoder.
interface video_pixel_feed_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        active_in;
  logic [16:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;
  logic        sync_lost;
  logic [15:0] err_cnt;

  modport master (
    output hsync_in, vsync_in, active_in, fifo_data, fifo_empty,
    input  fifo_rd, red, green, blue, hsync_out, vsync_out, de_out,
           sync_lost, err_cnt
  );

  modport slave (
    input  hsync_in, vsync_in, active_in, fifo_data, fifo_empty,
    output fifo_rd, red, green, blue, hsync_out, vsync_out, de_out,
           sync_lost, err_cnt
  );
endinterface

// File: rtl/video_pixel_feed.sv
// Pops RGB565 pixels from a show-ahead frame FIFO, expands them to RGB888 and
// aligns them to the sync generator's frames using the SOF marker bit.
module video_pixel_feed #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic              pixel_clock,
  input  logic              reset,
  video_pixel_feed_if.slave vif
);

  localparam logic [7:0] ERR_R = 8'hFF;
  localparam logic [7:0] ERR_G = 8'h00;
  localparam logic [7:0] ERR_B = 8'hFF;

  typedef enum logic [1:0] {WAIT_SOF, READY, STREAM, ERROR} state_e;

  state_e               state_q, state_d;
  logic                 first_pix_q, first_pix_d;
  logic                 vsync_d_q;
  logic [7:0]           red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                 hsync_q, vsync_q, de_q, sync_lost_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 err_evt, pop, vs_rise, head_sof;
  logic [4:0]           pix_r, pix_b;
  logic [5:0]           pix_g;

  assign vs_rise  = vif.vsync_in & ~vsync_d_q;
  assign head_sof = vif.fifo_data[16];
  assign pix_r    = vif.fifo_data[15:11];
  assign pix_g    = vif.fifo_data[10:5];
  assign pix_b    = vif.fifo_data[4:0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d     = state_q;
    first_pix_d = first_pix_q;
    pop         = 1'b0;
    err_evt     = 1'b0;
    red_d       = 8'h00;
    green_d     = 8'h00;
    blue_d      = 8'h00;
    case (state_q)
      WAIT_SOF: begin
        if (!vif.fifo_empty) begin
          if (head_sof) state_d = READY;
          else          pop     = 1'b1;
        end
      end
      READY: begin
        if (vs_rise) begin
          state_d     = STREAM;
          first_pix_d = 1'b1;
        end
      end
      STREAM: begin
        if (vs_rise) begin
          first_pix_d = 1'b1;
        end else if (vif.active_in) begin
          if (vif.fifo_empty) begin
            state_d = ERROR;
            err_evt = 1'b1;
            red_d   = ERR_R;
            green_d = ERR_G;
            blue_d  = ERR_B;
          end else if (head_sof != first_pix_q) begin
            // Frame boundary mismatch: hold the word and hunt for the next SOF.
            state_d = WAIT_SOF;
            err_evt = 1'b1;
          end else begin
            pop         = 1'b1;
            first_pix_d = 1'b0;
            red_d       = {pix_r, pix_r[4:2]};
            green_d     = {pix_g, pix_g[5:4]};
            blue_d      = {pix_b, pix_b[4:2]};
          end
        end
      end
      ERROR: begin
        if (vs_rise) begin
          state_d = WAIT_SOF;
        end else if (vif.active_in) begin
          red_d   = ERR_R;
          green_d = ERR_G;
          blue_d  = ERR_B;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  assign vif.fifo_rd = pop & ~reset;

  always_ff @(posedge pixel_clock) begin
    // NOTE: registers are updated with non-blocking assignments only.
    if (reset) begin
      state_q     <= WAIT_SOF;
      first_pix_q <= 1'b0;
      vsync_d_q   <= 1'b0;
      red_q       <= 8'h00;
      green_q     <= 8'h00;
      blue_q      <= 8'h00;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      sync_lost_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      first_pix_q <= first_pix_d;
      vsync_d_q   <= vif.vsync_in;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hsync_q     <= vif.hsync_in;
      vsync_q     <= vif.vsync_in;
      de_q        <= vif.active_in;
      sync_lost_q <= (state_q != STREAM);
      if (err_evt && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign vif.red       = red_q;
  assign vif.green     = green_q;
  assign vif.blue      = blue_q;
  assign vif.hsync_out = hsync_q;
  assign vif.vsync_out = vsync_q;
  assign vif.de_out    = de_q;
  assign vif.sync_lost = sync_lost_q;
  assign vif.err_cnt   = 16'(err_cnt_q);

endmodule

// File: tb/tb_video_pixel_feed.sv
// Self-checking bench for video_pixel_feed: a queue-backed FIFO, a small video
// timing generator and a frame-level reference model compared every cycle.
module tb_video_pixel_feed;

  localparam int H_ACT = 16, H_TOT = 24, V_ACT = 6, V_TOT = 9;
  localparam int FRAME_PIX = H_ACT * V_ACT;
  localparam int PERIOD    = H_TOT * V_TOT;
  localparam int CNT_W     = 6;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam logic [23:0] ERR_RGB = 24'hFF00FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_pixel_feed_if vif ();

  video_pixel_feed #(.ERR_CNT_W(CNT_W)) dut (
    .pixel_clock (clk),
    .reset       (rst),
    .vif         (vif)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] expand565(logic [15:0] p);
    int r5, g6, b5;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    return {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
  endfunction

  // ---------------- FIFO and stimulus state ----------------
  logic [16:0] q[$];
  int          pop_total = 0;
  logic        pop_seen  = 1'b0;
  int          h = 0, v = 0;

  // ---------------- reference model ----------------
  typedef enum {HUNT, ARMED, RUN, BROKEN} phase_e;
  typedef struct packed {
    logic [7:0]  r, g, b;
    logic        hs, vs, de, lost;
    logic [15:0] err;
  } outs_t;

  outs_t  exp_cur;
  phase_e m_phase    = HUNT;
  logic   m_want_sof = 1'b0;
  logic   m_prev_vs  = 1'b0;
  logic   m_valid    = 1'b0;
  int     m_err      = 0;

  always @(negedge clk) begin : model
    logic        rise, exp_pop, evt, lost_nxt;
    logic [23:0] rgb;
    if (m_valid) begin
      check("red",       vif.red,       exp_cur.r);
      check("green",     vif.green,     exp_cur.g);
      check("blue",      vif.blue,      exp_cur.b);
      check("hsync_out", vif.hsync_out, exp_cur.hs);
      check("vsync_out", vif.vsync_out, exp_cur.vs);
      check("de_out",    vif.de_out,    exp_cur.de);
      check("sync_lost", vif.sync_lost, exp_cur.lost);
      check("err_cnt",   vif.err_cnt,   exp_cur.err);
      if (vif.de_out === 1'b0) check("rgb_blank", {vif.red, vif.green, vif.blue}, 24'h0);
    end
    if (rst) begin
      check("fifo_rd_in_reset", vif.fifo_rd, 1'b0);
      exp_cur    = '0;
      m_phase    = HUNT;
      m_want_sof = 1'b0;
      m_prev_vs  = 1'b0;
      m_err      = 0;
      m_valid    = 1'b1;
    end else if (m_valid) begin
      rise     = vif.vsync_in & ~m_prev_vs;
      exp_pop  = 1'b0;
      evt      = 1'b0;
      rgb      = 24'h0;
      lost_nxt = (m_phase != RUN);
      if (m_phase == HUNT) begin
        if (!vif.fifo_empty) begin
          if (vif.fifo_data[16]) m_phase = ARMED;
          else                   exp_pop = 1'b1;
        end
      end else if (m_phase == ARMED) begin
        if (rise) begin
          m_phase    = RUN;
          m_want_sof = 1'b1;
        end
      end else if (m_phase == RUN) begin
        if (rise) m_want_sof = 1'b1;
        else if (vif.active_in) begin
          if (vif.fifo_empty) begin
            rgb = ERR_RGB; evt = 1'b1; m_phase = BROKEN;
          end else if (vif.fifo_data[16] != m_want_sof) begin
            evt = 1'b1; m_phase = HUNT;
          end else begin
            exp_pop = 1'b1; rgb = expand565(vif.fifo_data[15:0]); m_want_sof = 1'b0;
          end
        end
      end else begin
        if (rise) m_phase = HUNT;
        else if (vif.active_in) rgb = ERR_RGB;
      end
      check("fifo_rd", vif.fifo_rd, exp_pop);
      if (evt && m_err < CNT_MAX) m_err++;
      exp_cur = '{r: rgb[23:16], g: rgb[15:8], b: rgb[7:0], hs: vif.hsync_in, vs: vif.vsync_in,
                  de: vif.active_in, lost: lost_nxt, err: 16'(m_err)};
      m_prev_vs = vif.vsync_in;
    end
    pop_seen = (vif.fifo_rd === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_fifo();
    vif.fifo_empty = (q.size() == 0);
    vif.fifo_data  = (q.size() != 0) ? q[0] : 17'($urandom);
  endtask

  task automatic apply_pop();
    if (pop_seen && q.size() > 0) begin
      void'(q.pop_front());
      pop_total++;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    apply_pop();
    h++;
    if (h == H_TOT) begin h = 0; v = (v + 1) % V_TOT; end
    vif.active_in = (h < H_ACT) && (v < V_ACT);
    vif.hsync_in  = (h >= 18) && (h < 20);
    vif.vsync_in  = (v == 7);
    drive_fifo();
  endtask

  task automatic tick_manual(logic hs, logic vs, logic act, logic rs);
    @(posedge clk); #1;
    apply_pop();
    rst           = rs;
    vif.hsync_in  = hs;
    vif.vsync_in  = vs;
    vif.active_in = act;
    drive_fifo();
  endtask

  task automatic run_ticks(int n);
    repeat (n) tick();
  endtask

  task automatic push_frame(int len, int stray_at, logic [15:0] colour, bit rand_colour);
    for (int i = 0; i < len; i++)
      q.push_back({(i == 0) || (i == stray_at), rand_colour ? 16'($urandom) : colour});
  endtask

  task automatic push_junk(int n);
    for (int i = 0; i < n; i++) q.push_back({1'b0, 16'($urandom)});
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    vif.hsync_in = 1'b0; vif.vsync_in = 1'b0; vif.active_in = 1'b0;
    drive_fifo();
    repeat (n) begin @(posedge clk); #1; drive_fifo(); end
    check("reset_fifo_rd", vif.fifo_rd, 1'b0);
    check("reset_rgb",     {vif.red, vif.green, vif.blue}, 24'h0);
    check("reset_syncs",   {vif.hsync_out, vif.vsync_out, vif.de_out}, 3'b000);
    check("reset_lost",    vif.sync_lost, 1'b0);
    check("reset_err_cnt", vif.err_cnt, 16'h0);
    rst = 1'b0;
    h = H_TOT - 1;
    v = V_ACT - 1;
    pop_total = 0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic pvs, vs, act;
    int   kind;

    check("expand_F800", expand565(16'hF800), 24'hFF0000);
    check("expand_FFFF", expand565(16'hFFFF), 24'hFFFFFF);
    check("expand_0000", expand565(16'h0000), 24'h000000);
    check("expand_07E0", expand565(16'h07E0), 24'h00FF00);
    check("expand_8410", expand565(16'h8410), 24'h848284);

    // Reset with a full FIFO, then three clean red frames.
    push_junk(3);
    push_frame(FRAME_PIX, -1, 16'hF800, 1'b0);
    push_frame(FRAME_PIX, -1, 16'hF800, 1'b0);
    do_reset(3);
    tick();
    check("junk_pop_first", pop_total, 1);
    run_ticks(5);
    check("junk_pops", pop_total, 3);
    check("sof_at_head", q[0][16], 1'b1);
    run_ticks(PERIOD - 6);
    push_frame(FRAME_PIX, -1, 16'hF800, 1'b0);
    run_ticks(2 * PERIOD);
    check("clean_pops", pop_total, 3 + 3 * FRAME_PIX);
    check("clean_fifo_drained", q.size(), 0);
    check("clean_err_cnt", vif.err_cnt, 16'h0);
    check("clean_sync_lost", vif.sync_lost, 1'b0);

    // Underflow at pixel 10 of line 3.
    q.delete();
    push_frame(3 * H_ACT + 10, -1, 16'h0, 1'b1);
    do_reset(2);
    run_ticks(PERIOD);
    check("uf_err_cnt", vif.err_cnt, 16'd1);
    check("uf_sync_lost", vif.sync_lost, 1'b1);
    check("uf_pops", pop_total, 3 * H_ACT + 10);
    push_frame(FRAME_PIX, -1, 16'h0, 1'b1);
    run_ticks(PERIOD);
    check("uf_no_pops_armed", pop_total, 3 * H_ACT + 10);
    check("uf_still_lost", vif.sync_lost, 1'b1);
    run_ticks(PERIOD);
    check("uf_recover_pops", pop_total, 3 * H_ACT + 10 + FRAME_PIX);
    check("uf_recover_err", vif.err_cnt, 16'd1);
    check("uf_recover_lost", vif.sync_lost, 1'b0);

    // Desync: a new SOF appears at word 50 of a frame.
    q.delete();
    push_frame(50, -1, 16'h0, 1'b1);
    push_frame(FRAME_PIX, -1, 16'h0, 1'b1);
    do_reset(2);
    run_ticks(PERIOD);
    check("ds_err_cnt", vif.err_cnt, 16'd1);
    check("ds_sync_lost", vif.sync_lost, 1'b1);
    check("ds_pops", pop_total, 50);
    run_ticks(PERIOD);
    check("ds_resume_pops", pop_total, 50 + FRAME_PIX);
    check("ds_resume_err", vif.err_cnt, 16'd1);
    check("ds_resume_lost", vif.sync_lost, 1'b0);

    // Saturation: back-to-back desync events from a FIFO of SOF words.
    q.delete();
    for (int i = 0; i < 100; i++) q.push_back({1'b1, 16'($urandom)});
    do_reset(2);
    for (int i = 1; i <= CNT_MAX + 7; i++) begin
      tick_manual(1'b0, 1'b1, 1'b0, 1'b0);
      tick_manual(1'b0, 1'b1, 1'b1, 1'b0);
      tick_manual(1'b0, 1'b0, 1'b1, 1'b0);
      tick_manual(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == CNT_MAX - 1) check("sat_below_max", vif.err_cnt, 16'(CNT_MAX - 1));
    end
    check("sat_hold", vif.err_cnt, 16'(CNT_MAX));

    // Random sync/active patterns with random FIFO traffic and resets.
    q.delete();
    do_reset(2);
    pvs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      vs  = ($urandom_range(0, 15) == 0) ? ~pvs : pvs;
      act = ($urandom_range(0, 3) != 0) && !(vs && !pvs);
      if ($urandom_range(0, 2) == 0) q.push_back({$urandom_range(0, 7) == 0, 16'($urandom)});
      tick_manual(1'($urandom_range(0, 1)), vs, act, $urandom_range(0, 399) == 0);
      pvs = vs;
    end

    // Random frame-level faults under proper video timing.
    q.delete();
    do_reset(2);
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: push_frame(FRAME_PIX, -1, 16'h0, 1'b1);
        1: push_frame($urandom_range(1, FRAME_PIX - 1), -1, 16'h0, 1'b1);
        2: push_frame(FRAME_PIX, $urandom_range(1, FRAME_PIX - 1), 16'h0, 1'b1);
        3: begin push_junk($urandom_range(1, 5)); push_frame(FRAME_PIX, -1, 16'h0, 1'b1); end
        default: ;
      endcase
      run_ticks(PERIOD);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/video_pixel_feed.md
# video_pixel_feed

Pixel-data stage directly downstream of the video sync generator. It consumes the generator's hsync/vsync/active timing and pops RGB565 pixels from a show-ahead (first-word-fall-through) frame FIFO filled by the USB receive path. It expands each pixel to RGB888 and presents registered RGB, sync and data-enable to the video output encoder. It enforces frame alignment using a start-of-frame marker bit, and recovers from underflow and desync without CPU help.

## Interface
- ERR_R, 8'hFF: red component of the error colour.
- ERR_G, 8'h00: green component of the error colour.
- ERR_B, 8'hFF: blue component of the error colour.
- pixel_clock  in  1  video pixel clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator.
- active_in  in  1  visible-area flag from the timing generator.
- fifo_data  in  17  FIFO head word: [16] is SOF (first pixel of a frame), [15:0] is RGB565 (R[15:11], G[10:5], B[4:0]).
- fifo_empty  in  1  FIFO empty; fifo_data is valid only when low.
- fifo_rd  out  1  pop strobe, combinational; never asserted while fifo_empty=1.
- red, green, blue  out  8 each  registered pixel colour.
- hsync_out, vsync_out, de_out  out  1 each  registered copies of hsync_in, vsync_in, active_in.
- sync_lost  out  1  registered; high whenever the state is not STREAM.
- err_cnt  out  16  saturating count of underflow and desync events.

## Operation
- vs_rise = vsync_in & ~vsync_d, where vsync_d is vsync_in registered.
- States: WAIT_SOF, READY, STREAM, ERROR. Reset enters WAIT_SOF.
- WAIT_SOF:
  - If !fifo_empty and fifo_data[16]=0: pop (discard stale words), one word per cycle, regardless of active_in.
  - If !fifo_empty and fifo_data[16]=1: no pop; go to READY.
- READY:
  - Hold the SOF word without popping.
  - On vs_rise: go to STREAM and set first_pix=1.
- STREAM:
  - Outside active_in: no pops.
  - On vs_rise: set first_pix=1.
  - On each active_in cycle, check in this order:
    - fifo_empty: underflow. Output the error colour, go to ERROR, increment err_cnt.
    - fifo_data[16] != first_pix: desync. No pop, output black, go to WAIT_SOF, increment err_cnt.
    - Otherwise: pop, output the expanded pixel, clear first_pix.
- ERROR:
  - No pops.
  - Every active pixel outputs the error colour.
  - On vs_rise: go to WAIT_SOF, which flushes the remainder of the broken frame.
- In WAIT_SOF and READY, active pixels output black (0,0,0).
- Whenever active_in=0, RGB is 0.
- Expansion: red={R,R[4:2]}, green={G,G[5:4]}, blue={B,B[4:2]}. Examples: 16'hFFFF becomes FF/FF/FF; 16'h0000 becomes 00/00/00.
- err_cnt is incremented once per event (once per entry into ERROR, not once per pixel) and holds at 16'hFFFF.
- Frame content starts on the frame following vs_rise. An SOF that arrives after vs_rise in a blanking interval waits in READY for the next vs_rise (one frame dropped, no error counted).

## Timing
- All outputs are registered with exactly 1 pixel_clock latency from hsync_in/vsync_in/active_in/fifo_data to hsync_out/vsync_out/de_out/RGB.
- fifo_rd is combinational in the same cycle as the pixel it consumes. The FIFO advances at the next edge.
- Throughput: at most one pop per cycle.
- vs_rise takes priority over pixel handling in the same cycle (the timing generator never asserts active_in on a vs_rise cycle).
- Reset, synchronous:
  - State becomes WAIT_SOF; first_pix, vsync_d and all outputs go to 0; err_cnt goes to 0; fifo_rd is forced to 0 during reset.
  - Reset asserted mid-frame takes effect at the next edge and drops the in-flight frame. Resync happens via WAIT_SOF.
- State updates take effect on the edge following the decision. sync_lost reflects the new state one cycle after the transition.

## Test plan
- Reset with full FIFO: reset high for 3 cycles -> fifo_rd=0, all outputs 0, err_cnt=0; after release, non-SOF words are popped one per cycle until the SOF word is at the head.
- Clean frame, 1280x720, FIFO preloaded with SOF+921599 words of 16'hF800 -> after vs_rise, every de_out cycle gives red=FF, green=00, blue=00; exactly 921600 pops; err_cnt=0; sync_lost=0 from the first frame on.
- Underflow: FIFO runs empty at pixel 100 of line 5 -> that pixel and all later active pixels give FF/00/FF; err_cnt=1; no pops until the next vs_rise, then WAIT_SOF.
- Desync: SOF-flagged word appears at pixel 50 of line 0 -> black output, no pop, err_cnt increments, state WAIT_SOF; stream resumes one frame later with correct pixels.
- Saturation: force 65537 underflow events -> err_cnt holds 16'hFFFF.
- Latency check: random hsync/vsync/active patterns -> each *_out equals its *_in delayed exactly one cycle; RGB is 0 whenever de_out=0.
